// File: rtl/stats_dma_latency_accum.sv
// stats_dma_latency_accum: accumulates DMA completion stats into live counters and flushes them as AXI-stream increments; STATS_DMA_LATENCY_ACCUM_ERR_EN adds the error-count channel
module stats_dma_latency_accum #(
  parameter int LEN_WIDTH      = 16,
  parameter int STATUS_WIDTH   = 4,
  parameter int COUNT_WIDTH    = 16,
  parameter int STAT_INC_WIDTH = 24,
  parameter int STAT_ID_WIDTH  = 8,
  parameter int STAT_ID_BASE   = 0,
  parameter int UPDATE_PERIOD  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_WIDTH-1:0]      in_len,
  input  logic [STATUS_WIDTH-1:0]   in_status,
  input  logic [COUNT_WIDTH-1:0]    in_latency,
  input  logic                      in_valid,
  input  logic                      update,
  output logic [STAT_INC_WIDTH-1:0] m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]  m_axis_stat_tid,
  output logic                      m_axis_stat_tvalid,
  input  logic                      m_axis_stat_tready
);
`ifdef STATS_DMA_LATENCY_ACCUM_ERR_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int TW = $clog2(UPDATE_PERIOD);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [STAT_INC_WIDTH-1:0] live_q [NCH];
  logic [STAT_INC_WIDTH-1:0] live_d [NCH];
  logic [STAT_INC_WIDTH-1:0] live_add [NCH];
  logic [STAT_INC_WIDTH-1:0] shadow_q [NCH];
  logic [STAT_INC_WIDTH-1:0] shadow_d [NCH];
  logic [STAT_INC_WIDTH-1:0] inc [NCH];
  logic [STAT_INC_WIDTH-1:0] cur;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] idx_q, idx_d;
  logic pending_q, pending_d, trigger, msb_any, start;

  function automatic logic [STAT_INC_WIDTH-1:0] sat_add(input logic [STAT_INC_WIDTH-1:0] a, input logic [STAT_INC_WIDTH-1:0] b);
    logic [STAT_INC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_INC_WIDTH] ? '1 : s[STAT_INC_WIDTH-1:0];
  endfunction

  assign inc[0] = STAT_INC_WIDTH'(in_valid);
  assign inc[1] = in_valid ? STAT_INC_WIDTH'(in_len) : '0;
  assign inc[2] = in_valid ? STAT_INC_WIDTH'(in_latency) : '0;
`ifdef STATS_DMA_LATENCY_ACCUM_ERR_EN
  assign inc[3] = STAT_INC_WIDTH'(in_valid && in_status != '0);
`else
  logic unused_status;
  assign unused_status = ^in_status;
`endif

  // live counters plus this cycle's event, and the near-overflow flush request
  always_comb begin
    msb_any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      live_add[k] = sat_add(live_q[k], inc[k]);
      msb_any = msb_any | live_q[k][STAT_INC_WIDTH-1];
    end
  end

  assign trigger = (timer_q == TW'(UPDATE_PERIOD - 1)) || update || msb_any;
  assign timer_d = (start || timer_q == TW'(UPDATE_PERIOD - 1)) ? '0 : timer_q + TW'(1);
  assign cur = shadow_q[idx_q];
  assign m_axis_stat_tvalid = (state_q == SEND) && (cur != '0);
  assign m_axis_stat_tdata = m_axis_stat_tvalid ? cur : '0;
  assign m_axis_stat_tid = m_axis_stat_tvalid ? STAT_ID_WIDTH'(STAT_ID_BASE) + STAT_ID_WIDTH'(idx_q) : '0;

  // snapshot live into shadow on flush start, then walk the channels skipping zeros
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pending_d = pending_q;
    shadow_d = shadow_q;
    live_d = live_add;
    start = 1'b0;
    if (state_q == IDLE) begin
      if (trigger || pending_q) begin
        start = 1'b1;
        shadow_d = live_add;
        live_d = '{default: '0};
        idx_d = '0;
        pending_d = 1'b0;
        state_d = SEND;
      end
    end else begin
      pending_d = pending_q || trigger;
      if (cur == '0 || m_axis_stat_tready) begin
        idx_d = idx_q + 2'd1;
        state_d = (idx_q == 2'(NCH - 1)) ? IDLE : SEND;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      pending_q <= 1'b0;
      timer_q <= '0;
      live_q <= '{default: '0};
      shadow_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pending_q <= pending_d;
      timer_q <= timer_d;
      live_q <= live_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: tb/tb_stats_dma_latency_accum.sv
// tb_stats_dma_latency_accum: scoreboard bench for the DMA latency stats accumulator
module tb_stats_dma_latency_accum;
  localparam int LW = 16;
  localparam int SW = 4;
  localparam int CW = 16;
  localparam int IW = 17;
  localparam int DW = 8;
  localparam int PERIOD = 64;

  logic clk, rst, in_valid, update, tvalid, tready;
  logic [LW-1:0] in_len;
  logic [SW-1:0] in_status;
  logic [CW-1:0] in_latency;
  logic [IW-1:0] tdata;
  logic [DW-1:0] tid;
  logic [DW+IW-1:0] sb [$];
  logic [DW+IW-1:0] exp_beat;
  int checks = 0;
  int errors = 0;

  stats_dma_latency_accum #(
    .LEN_WIDTH(LW), .STATUS_WIDTH(SW), .COUNT_WIDTH(CW), .STAT_INC_WIDTH(IW),
    .STAT_ID_WIDTH(DW), .STAT_ID_BASE(0), .UPDATE_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .in_len(in_len), .in_status(in_status), .in_latency(in_latency),
    .in_valid(in_valid), .update(update), .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid),
    .m_axis_stat_tvalid(tvalid), .m_axis_stat_tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got tid=%0d tdata=%0h, expected no beat", tid, tdata);
      end else begin
        exp_beat = sb.pop_front();
        if ({tid, tdata} !== exp_beat) begin
          errors++;
          $display("FAIL beat: got tid=%0d tdata=%0h, expected tid=%0d tdata=%0h",
                   tid, tdata, exp_beat[DW+IW-1:IW], exp_beat[IW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int t, input int d);
    sb.push_back({DW'(t), IW'(d)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    update = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ev(input int len, input int lat, input int st);
    in_valid = 1'b1;
    in_len = LW'(len);
    in_latency = CW'(lat);
    in_status = SW'(st);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    tready = 1'b1;
    do_reset();
    checks += 3;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0h expected 0", tdata); end
    if (tid !== '0) begin errors++; $display("FAIL reset_tid: got %0h expected 0", tid); end
  endtask

  task automatic test_basic();
    do_reset();
    tready = 1'b1;
    ev(64, 100, 0);
    push(0, 1); push(1, 64); push(2, 100);
    pulse_update();
    wait_drain();
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
    if (tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle_tvalid: got %b expected 0", tvalid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tready = 1'b0;
    ev(4, 9, 0);
    push(0, 1); push(1, 4); push(2, 9);
    pulse_update();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tid !== 8'd0 || tdata !== 17'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b tid=%0d tdata=%0h expected v=1 tid=0 tdata=1", i, tvalid, tid, tdata);
      end
      in_valid = (i < 5);
      in_len = 16'd8;
      in_latency = 16'd10;
      in_status = '0;
      tick();
    end
    in_valid = 1'b0;
    tready = 1'b1;
    wait_drain();
    push(0, 5); push(1, 40); push(2, 50);
    pulse_update();
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    tready = 1'b1;
    push(0, 1); push(1, 16); push(2, 7);
    update = 1'b1;
    ev(16, 7, 0);
    update = 1'b0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL same_cycle_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_timer();
    int cyc;
    do_reset();
    tready = 1'b1;
    tick();
    tick();
    push(0, 1); push(1, 3); push(2, 5);
    ev(3, 5, 0);
    cyc = 3;
    while (!tvalid && cyc < 4 * PERIOD) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != PERIOD) begin errors++; $display("FAIL timer_first_tvalid: got cycle %0d expected %0d", cyc, PERIOD); end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL timer_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_saturation_trigger();
    do_reset();
    tready = 1'b1;
    push(0, 2); push(1, 'h1FFFE);
    ev('hFFFF, 0, 0);
    ev('hFFFF, 0, 0);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL msb_pre: got %b expected 0", tvalid); end
    tick();
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("FAIL msb_flush_start: got %b expected 1", tvalid); end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL msb_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_errors();
    do_reset();
    tready = 1'b1;
    ev(1, 1, 3);
    ev(1, 1, 0);
    push(0, 2); push(1, 2); push(2, 2);
`ifdef STATS_DMA_LATENCY_ACCUM_ERR_EN
    push(3, 1);
`endif
    pulse_update();
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL err_drain: got %0d outstanding expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    tready = 1'b0;
    ev(5, 5, 0);
    pulse_update();
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b expected 1", tvalid); end
    rst = 1'b1;
    in_valid = 1'b1;
    in_len = 16'd9;
    in_latency = 16'd9;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b expected 0", tvalid); end
    tready = 1'b1;
    pulse_update();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL zero_flush[%0d]: got tvalid %b expected 0", i, tvalid); end
      tick();
    end
  endtask

  initial begin
    tready = 1'b1;
    in_len = '0;
    in_status = '0;
    in_latency = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_same_cycle();
    test_timer();
    test_saturation_trigger();
    test_errors();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
